// File: rtl/alu_counter_demux.sv
// 74181-style 16-bit ALU, loadable up-counter and 3-to-8 active-low demux.
// Only the counter is clocked/reset; ALU and demux are pure combinational paths.
module alu_counter_demux #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 _reset,
  input  logic                 alu_mode,
  input  logic [3:0]           alu_op,
  input  logic                 c_in,
  input  logic [15:0]          x,
  input  logic [15:0]          y,
  output logic [15:0]          z,
  input  logic                 cnt_ce,
  input  logic                 cnt_load,
  input  logic [CNT_WIDTH-1:0] cnt_preset,
  output logic [CNT_WIDTH-1:0] cnt_out,
  input  logic [2:0]           dmx_sel,
  output logic [7:0]           dmx_out
);

  logic [15:0]          w_f;
  logic [15:0]          w_anb;
  logic [15:0]          w_aob;
  logic [15:0]          w_aonb;
  logic [15:0]          w_ab;
  logic [CNT_WIDTH-1:0] r_cnt;

  assign w_anb  = x & ~y;
  assign w_aob  = x | y;
  assign w_aonb = x | ~y;
  assign w_ab   = x & y;

  always_comb begin
    w_f = '0;
    if (alu_mode) begin
      case (alu_op)
        4'h0: w_f = ~x;
        4'h1: w_f = ~w_aob;
        4'h2: w_f = ~x & y;
        4'h3: w_f = '0;
        4'h4: w_f = ~w_ab;
        4'h5: w_f = ~y;
        4'h6: w_f = x ^ y;
        4'h7: w_f = w_anb;
        4'h8: w_f = ~x | y;
        4'h9: w_f = ~(x ^ y);
        4'hA: w_f = y;
        4'hB: w_f = w_ab;
        4'hC: w_f = '1;
        4'hD: w_f = w_aonb;
        4'hE: w_f = w_aob;
        default: w_f = x;
      endcase
    end else begin
      // carry-out is dropped: every sum below truncates to 16 bits
      case (alu_op)
        4'h0: w_f = x;
        4'h1: w_f = w_aob;
        4'h2: w_f = w_aonb;
        4'h3: w_f = '1;
        4'h4: w_f = x + w_anb;
        4'h5: w_f = w_aob + w_anb;
        4'h6: w_f = x + ~y;
        4'h7: w_f = w_anb - 16'd1;
        4'h8: w_f = x + w_ab;
        4'h9: w_f = x + y;
        4'hA: w_f = w_aonb + w_ab;
        4'hB: w_f = w_ab - 16'd1;
        4'hC: w_f = x + x;
        4'hD: w_f = w_aob + x;
        4'hE: w_f = w_aonb + x;
        default: w_f = x - 16'd1;
      endcase
    end
  end

  assign z = alu_mode ? w_f : w_f + {15'd0, c_in};

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_cnt <= '0;
    end else if (cnt_load) begin
      r_cnt <= cnt_preset;
    end else if (cnt_ce) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign cnt_out = r_cnt;
  assign dmx_out = ~(8'd1 << dmx_sel);

endmodule

// File: tb/tb_alu_counter_demux.sv
// Directed + randomized bench for alu_counter_demux against a truth-table /
// integer-arithmetic reference model.
module tb_alu_counter_demux;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          _reset;
  logic          alu_mode;
  logic [3:0]    alu_op;
  logic          c_in;
  logic [15:0]   x, y, z;
  logic          cnt_ce, cnt_load;
  logic [W-1:0]  cnt_preset, cnt_out;
  logic [2:0]    dmx_sel;
  logic [7:0]    dmx_out;

  int checks = 0;
  int errors = 0;
  longint m_cnt = 0;

  // logic-mode truth tables, bit index = {a,b}
  logic [3:0] lt [16] = '{4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h5, 4'h6, 4'h4,
                          4'hB, 4'h9, 4'hA, 4'h8, 4'hF, 4'hD, 4'hE, 4'hC};

  alu_counter_demux #(.CNT_WIDTH(W)) dut (
    .clk(clk), ._reset(_reset), .alu_mode(alu_mode), .alu_op(alu_op),
    .c_in(c_in), .x(x), .y(y), .z(z), .cnt_ce(cnt_ce), .cnt_load(cnt_load),
    .cnt_preset(cnt_preset), .cnt_out(cnt_out), .dmx_sel(dmx_sel),
    .dmx_out(dmx_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_alu(input logic mode, input logic [3:0] op,
                                        input logic cin, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  t;
    longint A, f;
    r = '0;
    if (mode) begin
      t = lt[op];
      for (int i = 0; i < 16; i++) r[i] = t[{a[i], b[i]}];
      return r;
    end
    A = longint'(a);
    case (op)
      4'h0: f = A;
      4'h1: f = longint'(a | b);
      4'h2: f = longint'(a | ~b);
      4'h3: f = 65535;
      4'h4: f = A + longint'(a & ~b);
      4'h5: f = longint'(a | b) + longint'(a & ~b);
      4'h6: f = A - longint'(b) - 1;
      4'h7: f = longint'(a & ~b) - 1;
      4'h8: f = A + longint'(a & b);
      4'h9: f = A + longint'(b);
      4'hA: f = longint'(a | ~b) + longint'(a & b);
      4'hB: f = longint'(a & b) - 1;
      4'hC: f = 2 * A;
      4'hD: f = longint'(a | b) + A;
      4'hE: f = longint'(a | ~b) + A;
      default: f = A - 1;
    endcase
    f = (f + longint'(cin) + 65536 * 4) % 65536;
    return 16'(f);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    logic [7:0] e;
    #1;
    chk({tag, "_alu"}, 32'(z), 32'(m_alu(alu_mode, alu_op, c_in, x, y)));
    for (int i = 0; i < 8; i++) e[i] = (i != int'(dmx_sel));
    chk({tag, "_dmx"}, 32'(dmx_out), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!_reset)       m_cnt = 0;
    else if (cnt_load) m_cnt = longint'(cnt_preset);
    else if (cnt_ce)   m_cnt = (m_cnt + 1) % (longint'(1) << W);
    #1;
  endtask

  task automatic alu_dir(input string tag, input logic mode, input logic [3:0] op,
                         input logic cin, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
    alu_mode = mode; alu_op = op; c_in = cin; x = a; y = b;
    #1;
    chk(tag, 32'(z), 32'(exp));
    chk({tag, "_model"}, 32'(z), 32'(m_alu(mode, op, cin, a, b)));
  endtask

  initial begin
    _reset = 1'b0; alu_mode = 1'b0; alu_op = '0; c_in = 1'b0; x = '0; y = '0;
    cnt_ce = 1'b0; cnt_load = 1'b0; cnt_preset = '0; dmx_sel = '0;
    #2;
    chk("rst_cnt", 32'(cnt_out), 32'd0);

    // counter held at zero across edges while reset is low
    cnt_ce = 1'b1; cnt_load = 1'b1; cnt_preset = 16'h1234;
    tick(); tick();
    chk("rst_hold_cnt", 32'(cnt_out), 32'd0);

    // demux sweep with reset asserted
    for (int s = 0; s < 8; s++) begin
      dmx_sel = 3'(s);
      #1;
      chk("dmx_rst", 32'(dmx_out), 32'(8'hFF ^ (8'd1 << s)));
    end

    alu_dir("add",      1'b0, 4'h9, 1'b0, 16'h1234, 16'h0FFF, 16'h2233);
    alu_dir("add_wrap", 1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000);
    alu_dir("sub",      1'b0, 4'h6, 1'b1, 16'h0005, 16'h0007, 16'hFFFE);
    alu_dir("dec",      1'b0, 4'hF, 1'b0, 16'h0000, 16'h0000, 16'hFFFF);
    alu_dir("inc",      1'b0, 4'h0, 1'b1, 16'h00FF, 16'h0000, 16'h0100);
    alu_dir("and",      1'b1, 4'hB, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000);
    alu_dir("or",       1'b1, 4'hE, 1'b0, 16'hF0F0, 16'hFF00, 16'hFFF0);
    alu_dir("xor",      1'b1, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0);
    alu_dir("nota",     1'b1, 4'h0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0F0F);
    alu_dir("zero",     1'b1, 4'h3, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000);
    alu_dir("passb",    1'b1, 4'hA, 1'b0, 16'hF0F0, 16'hFF00, 16'hFF00);
    alu_dir("xor_cin",  1'b1, 4'h6, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0);
    alu_dir("and_cin",  1'b1, 4'hB, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000);

    // release and count three edges
    @(negedge clk);
    _reset = 1'b1; cnt_load = 1'b0; cnt_ce = 1'b1;
    tick(); tick(); tick();
    chk("cnt3", 32'(cnt_out), 32'd3);
    chk("cnt3_model", 32'(cnt_out), 32'(m_cnt));
    @(negedge clk); cnt_ce = 1'b0;
    tick(); tick();
    chk("hold3", 32'(cnt_out), 32'd3);
    @(negedge clk); cnt_load = 1'b1; cnt_ce = 1'b1; cnt_preset = 16'hFFFF;
    tick();
    chk("load_pri", 32'(cnt_out), 32'h0000FFFF);
    @(negedge clk); cnt_load = 1'b0;
    tick();
    chk("wrap", 32'(cnt_out), 32'd0);

    // asynchronous reset between edges while counting
    @(negedge clk); cnt_load = 1'b1; cnt_preset = 16'h0042; cnt_ce = 1'b1;
    tick();
    chk("load42", 32'(cnt_out), 32'h42);
    cnt_load = 1'b0;
    #2 _reset = 1'b0; m_cnt = 0;
    #1 chk("async_rst", 32'(cnt_out), 32'd0);
    #1 _reset = 1'b1;
    tick();
    chk("post_rst", 32'(cnt_out), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      alu_mode   = 1'($urandom);
      alu_op     = 4'($urandom);
      c_in       = 1'($urandom);
      x          = 16'($urandom);
      y          = 16'($urandom);
      dmx_sel    = 3'($urandom);
      cnt_ce     = ($urandom_range(0, 3) != 0);
      cnt_load   = ($urandom_range(0, 9) == 0);
      cnt_preset = ($urandom_range(0, 1) == 0) ? 16'hFFFE : W'($urandom);
      chk_comb("rnd");
      tick();
      chk("rnd_cnt", 32'(cnt_out), 32'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
